mem_lsu: RTL

//  Load/store initiator driving the word-addressed ideal_mem ports (async read, sync write) for the multi-cycle CPU.

---
 rtl/mem_lsu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// Load/store unit between the multi-cycle CPU datapath and ideal_mem.
// Sub-word stores use read-modify-write; loads are returned zero- or sign-extended.
module mem_lsu #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [1:0]            req_size,
   input  logic                  req_sext,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_raddr,
   output logic                  mem_rden,
   input  logic [31:0]           mem_rdata,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic                  mem_wren,
   output logic [31:0]           mem_wdata
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_RESP} state_e;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD} size_e;

   state_e                state_q, state_d;
   logic                  wr_q, wr_d;
   size_e                 size_q, size_d;
   logic                  sext_q, sext_d;
   logic [1:0]            off_q, off_d;
   logic [ADDR_WIDTH-1:0] word_q, word_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [31:0]           mwdata_q, mwdata_d;

   // Address bits above the memory size alias onto the same words.
   logic                  unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH];

   logic [ADDR_WIDTH-1:0] req_word;
   logic                  req_bad;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [31:0]           merged;
   logic [31:0]           load_val;

   assign req_word = {2'b00, req_addr[ADDR_WIDTH-1:2]};
   assign req_bad  = (req_size == SZ_BAD)
                   | ((req_size == SZ_HALF) & req_addr[0])
                   | ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));

   assign rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
   assign rd_half = mem_rdata[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      merged = mem_rdata;
      case (size_q)
         SZ_BYTE: merged[{off_q, 3'b000} +: 8]     = wdata_q[7:0];
         SZ_HALF: merged[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   always_comb begin
      case (size_q)
         SZ_BYTE: load_val = {{24{sext_q & rd_byte[7]}}, rd_byte};
         SZ_HALF: load_val = {{16{sext_q & rd_half[15]}}, rd_half};
         default: load_val = mem_rdata;
      endcase
   end

   // NOTE: every _d is defaulted to its _q first, so no path leaves a
   // variable unassigned and no latch can be inferred.
   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      size_d   = size_q;
      sext_d   = sext_q;
      off_d    = off_q;
      word_d   = word_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      raddr_d  = raddr_q;
      waddr_d  = waddr_q;
      mwdata_d = mwdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               wr_d    = req_wr;
               size_d  = size_e'(req_size);
               sext_d  = req_sext;
               off_d   = req_addr[1:0];
               word_d  = req_word;
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = 1'b0;
               if (req_bad) begin
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else if (!req_wr || (req_size != SZ_WORD)) begin
                  raddr_d = req_word;
                  state_d = S_READ;
               end else begin
                  waddr_d  = req_word;
                  mwdata_d = req_wdata;
                  state_d  = S_WRITE;
               end
            end
         end
         S_READ: begin
            if (wr_q) begin
               waddr_d  = word_q;
               mwdata_d = merged;
               state_d  = S_WRITE;
            end else begin
               rdata_d = load_val;
               state_d = S_RESP;
            end
         end
         S_WRITE: state_d = S_RESP;
         S_RESP: begin
            if (resp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= S_IDLE;
         wr_q     <= 1'b0;
         size_q   <= SZ_BYTE;
         sext_q   <= 1'b0;
         off_q    <= '0;
         word_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         raddr_q  <= '0;
         waddr_q  <= '0;
         mwdata_q <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         size_q   <= size_d;
         sext_q   <= sext_d;
         off_q    <= off_d;
         word_q   <= word_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         raddr_q  <= raddr_d;
         waddr_q  <= waddr_d;
         mwdata_q <= mwdata_d;
      end
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_rden   = (state_q == S_READ);
   assign mem_wren   = (state_q == S_WRITE);
   assign mem_raddr  = raddr_q;
   assign mem_waddr  = waddr_q;
   assign mem_wdata  = mwdata_q;

endmodule
